// File: rtl/move_link_ctrl.sv
// Link sequencer between game logic and the UART tx/rx pair: frames local moves, waits for
// the peer's ACK with timeout/retry, filters received moves and arbitrates the tx channel.
module move_link_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 6_500_000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned PKT_LEN     = 8
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               move_valid_in,
    input  logic [PKT_LEN-2:0] move_in,
    input  logic               rx_ready_in,
    input  logic [PKT_LEN-1:0] rx_data_in,
    input  logic               tx_busy_in,
    output logic               tx_trigger_out,
    output logic [PKT_LEN-1:0] tx_val_out,
    output logic               rx_move_valid_out,
    output logic [PKT_LEN-2:0] rx_move_out,
    output logic               move_done_out,
    output logic               link_busy_out,
    output logic               link_error_out,
    output logic [1:0]         retry_cnt_out
);

    typedef enum logic [2:0] {
        StIdle,
        StTxStart,
        StTxWait,
        StWaitAck,
        StError
    } tx_state_e;

    typedef enum logic [1:0] {
        ChIdle,
        ChRise,
        ChBusy
    } ch_state_e;

    localparam logic [PKT_LEN-2:0] AckCode   = '1;
    localparam logic [22:0]        TimerLast = 23'(ACK_TIMEOUT - 1);
    localparam logic [22:0]        TimerMax  = '1;
    localparam logic [1:0]         RetryMax  = 2'(MAX_RETRIES);

    // Tx sequencing state
    tx_state_e          state_q, state_d;
    logic               launched_q, launched_d;
    logic [PKT_LEN-1:0] frame_q, frame_d;
    logic               tx_seq_q, tx_seq_d;
    logic [22:0]        timer_q, timer_d;
    logic [1:0]         retry_cnt_q, retry_cnt_d;
    logic               move_done_q, move_done_d;
    logic               link_busy_q, link_busy_d;
    logic               link_error_q, link_error_d;

    // Shared tx channel
    ch_state_e          ch_q, ch_d;
    logic [1:0]         rise_cnt_q, rise_cnt_d;
    logic               trigger_q, trigger_d;
    logic [PKT_LEN-1:0] tx_val_q, tx_val_d;

    // Rx filtering and ACK generation
    logic               rx_exp_seq_q, rx_exp_seq_d;
    logic               ack_pending_q, ack_pending_d;
    logic               ack_seq_q, ack_seq_d;
    logic [PKT_LEN-2:0] rx_move_q, rx_move_d;
    logic               rx_move_valid_q, rx_move_valid_d;

    logic rx_is_ack;
    logic rx_is_move;
    logic ack_match;
    logic ch_free;
    logic grant_ack;
    logic grant_move;
    logic rise_done;
    logic timeout;

    always_comb begin
        rx_is_ack  = rx_ready_in && (rx_data_in[PKT_LEN-2:0] == AckCode);
        rx_is_move = rx_ready_in && (rx_data_in[PKT_LEN-2:0] != AckCode);
        ack_match  = rx_is_ack && (rx_data_in[PKT_LEN-1] == tx_seq_q);
        ch_free    = (ch_q == ChIdle) && !tx_busy_in;
        grant_ack  = ch_free && ack_pending_q;
        grant_move = ch_free && !ack_pending_q && (state_q == StTxStart) && !launched_q;
        // Busy seen, or four cycles elapsed since the trigger without a rise
        rise_done  = (ch_q == ChRise) && (tx_busy_in || (rise_cnt_q == 2'd3));
        timeout    = (timer_q == TimerLast);
    end

    // Channel: one trigger at a time, held until the frame's busy window closes
    always_comb begin
        ch_d       = ch_q;
        rise_cnt_d = rise_cnt_q;
        trigger_d  = 1'b0;
        tx_val_d   = tx_val_q;
        unique case (ch_q)
            ChIdle: begin
                if (grant_ack || grant_move) begin
                    ch_d       = ChRise;
                    rise_cnt_d = 2'd0;
                    trigger_d  = 1'b1;
                    tx_val_d   = grant_ack ? {ack_seq_q, AckCode} : frame_q;
                end
            end
            ChRise: begin
                if (tx_busy_in) begin
                    ch_d = ChBusy;
                end else if (rise_cnt_q == 2'd3) begin
                    ch_d = ChIdle;
                end else begin
                    rise_cnt_d = rise_cnt_q + 2'd1;
                end
            end
            ChBusy: begin
                if (!tx_busy_in) begin
                    ch_d = ChIdle;
                end
            end
            default: ch_d = ChIdle;
        endcase
    end

    // Rx: deliver in-sequence moves, acknowledge every move frame
    always_comb begin
        rx_exp_seq_d    = rx_exp_seq_q;
        ack_pending_d   = ack_pending_q;
        ack_seq_d       = ack_seq_q;
        rx_move_d       = rx_move_q;
        rx_move_valid_d = 1'b0;
        if (rx_is_move) begin
            ack_pending_d = 1'b1;
            ack_seq_d     = rx_data_in[PKT_LEN-1];
            if (rx_data_in[PKT_LEN-1] == rx_exp_seq_q) begin
                rx_move_d       = rx_data_in[PKT_LEN-2:0];
                rx_move_valid_d = 1'b1;
                rx_exp_seq_d    = ~rx_exp_seq_q;
            end
        end else if (grant_ack) begin
            ack_pending_d = 1'b0;
        end
    end

    // Tx FSM
    always_comb begin
        state_d      = state_q;
        launched_d   = launched_q;
        frame_d      = frame_q;
        tx_seq_d     = tx_seq_q;
        timer_d      = timer_q;
        retry_cnt_d  = retry_cnt_q;
        move_done_d  = 1'b0;
        link_busy_d  = link_busy_q;
        link_error_d = link_error_q;
        unique case (state_q)
            StIdle: begin
                if (move_valid_in) begin
                    frame_d     = {tx_seq_q, move_in};
                    link_busy_d = 1'b1;
                    retry_cnt_d = 2'd0;
                    launched_d  = 1'b0;
                    state_d     = StTxStart;
                end
            end
            StTxStart: begin
                if (grant_move) begin
                    launched_d = 1'b1;
                end else if (launched_q && rise_done) begin
                    state_d = StTxWait;
                end
            end
            StTxWait: begin
                if (!tx_busy_in) begin
                    timer_d = 23'd0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                timer_d = (timer_q == TimerMax) ? timer_q : timer_q + 23'd1;
                // ACK takes precedence over a coincident timeout
                if (ack_match) begin
                    tx_seq_d    = ~tx_seq_q;
                    move_done_d = 1'b1;
                    link_busy_d = 1'b0;
                    state_d     = StIdle;
                end else if (timeout) begin
                    if (retry_cnt_q < RetryMax) begin
                        retry_cnt_d = retry_cnt_q + 2'd1;
                        launched_d  = 1'b0;
                        state_d     = StTxStart;
                    end else begin
                        link_error_d = 1'b1;
                        link_busy_d  = 1'b0;
                        state_d      = StError;
                    end
                end
            end
            StError: begin
                state_d = StError;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_q         <= StIdle;
            launched_q      <= 1'b0;
            frame_q         <= '0;
            tx_seq_q        <= 1'b0;
            timer_q         <= 23'd0;
            retry_cnt_q     <= 2'd0;
            move_done_q     <= 1'b0;
            link_busy_q     <= 1'b0;
            link_error_q    <= 1'b0;
            ch_q            <= ChIdle;
            rise_cnt_q      <= 2'd0;
            trigger_q       <= 1'b0;
            tx_val_q        <= '0;
            rx_exp_seq_q    <= 1'b0;
            ack_pending_q   <= 1'b0;
            ack_seq_q       <= 1'b0;
            rx_move_q       <= '0;
            rx_move_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            launched_q      <= launched_d;
            frame_q         <= frame_d;
            tx_seq_q        <= tx_seq_d;
            timer_q         <= timer_d;
            retry_cnt_q     <= retry_cnt_d;
            move_done_q     <= move_done_d;
            link_busy_q     <= link_busy_d;
            link_error_q    <= link_error_d;
            ch_q            <= ch_d;
            rise_cnt_q      <= rise_cnt_d;
            trigger_q       <= trigger_d;
            tx_val_q        <= tx_val_d;
            rx_exp_seq_q    <= rx_exp_seq_d;
            ack_pending_q   <= ack_pending_d;
            ack_seq_q       <= ack_seq_d;
            rx_move_q       <= rx_move_d;
            rx_move_valid_q <= rx_move_valid_d;
        end
    end

    assign tx_trigger_out    = trigger_q;
    assign tx_val_out        = tx_val_q;
    assign rx_move_valid_out = rx_move_valid_q;
    assign rx_move_out       = rx_move_q;
    assign move_done_out     = move_done_q;
    assign link_busy_out     = link_busy_q;
    assign link_error_out    = link_error_q;
    assign retry_cnt_out     = retry_cnt_q;

endmodule

// File: tb/tb_move_link_ctrl.sv
// Scoreboard bench for move_link_ctrl with a 20-cycle-busy tx model.
module tb_move_link_ctrl;

    localparam int AckTo   = 100;
    localparam int BusyLen = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_valid;
    logic [6:0] move_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_trigger_out;
    logic [7:0] tx_val_out;
    logic       rx_move_valid_out;
    logic [6:0] rx_move_out;
    logic       move_done_out;
    logic       link_busy_out;
    logic       link_error_out;
    logic [1:0] retry_cnt_out;
    logic [21:0] all_outs;

    move_link_ctrl #(
        .ACK_TIMEOUT(AckTo),
        .MAX_RETRIES(3),
        .PKT_LEN    (8)
    ) dut (
        .clk_in           (clk),
        .rst_in_n         (rst_n),
        .move_valid_in    (move_valid),
        .move_in          (move_in),
        .rx_ready_in      (rx_ready),
        .rx_data_in       (rx_data),
        .tx_busy_in       (tx_busy),
        .tx_trigger_out   (tx_trigger_out),
        .tx_val_out       (tx_val_out),
        .rx_move_valid_out(rx_move_valid_out),
        .rx_move_out      (rx_move_out),
        .move_done_out    (move_done_out),
        .link_busy_out    (link_busy_out),
        .link_error_out   (link_error_out),
        .retry_cnt_out    (retry_cnt_out)
    );

    assign all_outs = {tx_trigger_out, tx_val_out, rx_move_valid_out, rx_move_out,
                       move_done_out, link_busy_out, link_error_out, retry_cnt_out};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // tx model: busy high for BusyLen cycles starting the cycle after the trigger
    int busy_left;
    always @(posedge clk) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_trigger_out) begin
            tx_busy   <= 1'b1;
            busy_left <= BusyLen;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            tx_busy   <= (busy_left > 1);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    logic [7:0] exp_tx[$];
    logic [6:0] exp_rx[$];
    int trig_count   = 0;
    int rxv_count    = 0;
    int done_count   = 0;
    int last_rxv_cyc = -1;

    always @(negedge clk) begin
        if (tx_trigger_out) begin
            trig_count++;
            check("tx_frame_expected", 32'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) check("tx_frame", 32'(tx_val_out), 32'(exp_tx.pop_front()));
        end
        if (rx_move_valid_out) begin
            rxv_count++;
            last_rxv_cyc = cyc;
            check("rx_move_expected", 32'(exp_rx.size() != 0), 1);
            if (exp_rx.size() != 0) check("rx_move", 32'(rx_move_out), 32'(exp_rx.pop_front()));
        end
        if (move_done_out) done_count++;
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_move(input logic [6:0] m, output int vc);
        move_valid = 1'b1;
        move_in    = m;
        vc         = cyc;
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d, output int rc);
        rx_ready = 1'b1;
        rx_data  = d;
        rc       = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_trig(input string tag, input int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_trigger_out) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check({tag, "_timeout"}, 32'(tx_trigger_out), 1);
    endtask

    task automatic wait_fall(output int f);
        f = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx_busy) begin
                f = cyc;
                break;
            end
        end
        if (f < 0) check("busy_fall_timeout", 32'(tx_busy), 0);
    endtask

    // Send one move, check its frame/latency, then acknowledge it
    task automatic move_round(input logic [6:0] m, input logic [7:0] frame,
                              input logic [7:0] ack);
        int vc, c, f, rc, dc;
        exp_tx.push_back(frame);
        send_move(m, vc);
        wait_trig("move_trig", 10, c);
        check("move_latency", 32'(c - vc), 2);
        check("move_busy_set", 32'(link_busy_out), 1);
        wait_fall(f);
        idle(5);
        dc = done_count;
        rx_pulse(ack, rc);
        idle(3);
        check("move_done", 32'(done_count - dc), 1);
        check("move_busy_clr", 32'(link_busy_out), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int vc, rc, c, f, tc, dc, rv;
        rst_n      = 1'b0;
        move_valid = 1'b0;
        move_in    = 7'h00;
        rx_ready   = 1'b0;
        rx_data    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(all_outs), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic send and sequence toggle
        move_round(7'h2A, 8'h2A, 8'h7F);
        move_round(7'h05, 8'h85, 8'hFF);

        // Receive: new, duplicate, next sequence
        rv = rxv_count;
        exp_rx.push_back(7'h33);
        exp_tx.push_back(8'h7F);
        rx_pulse(8'h33, rc);
        wait_trig("rx_ack1", 10, c);
        check("rx_latency", 32'(last_rxv_cyc - rc), 1);
        wait_fall(f);
        exp_tx.push_back(8'h7F);
        rx_pulse(8'h33, rc);
        wait_trig("rx_ack2", 10, c);
        wait_fall(f);
        check("rx_dup_dropped", 32'(rxv_count - rv), 1);
        exp_rx.push_back(7'h34);
        exp_tx.push_back(8'hFF);
        rx_pulse(8'hB4, rc);
        wait_trig("rx_ack3", 10, c);
        wait_fall(f);
        check("rx_count", 32'(rxv_count - rv), 2);
        check("rx_move_hold", 32'(rx_move_out), 32'h34);

        // Reset during TX_WAIT with both sequence bits at 1
        move_round(7'h20, 8'h20, 8'h7F);
        exp_rx.push_back(7'h45);
        exp_tx.push_back(8'h7F);
        rx_pulse(8'h45, rc);
        wait_trig("rst_rx_ack", 10, c);
        wait_fall(f);
        exp_tx.push_back(8'h91);
        send_move(7'h11, vc);
        wait_trig("rst_move", 10, c);
        idle(5);
        check("rst_pre_busy", 32'(link_busy_out), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_outs_mid", 32'(all_outs), 0);
        rst_n = 1'b1;
        tc = trig_count;
        idle(200);
        check("rst_no_trig", 32'(trig_count - tc), 0);

        // Arbitration: ACK first, seqs back at 0; wrong ACK ignored; ACK in timeout cycle wins
        exp_tx.push_back(8'h7F);
        exp_tx.push_back(8'h02);
        exp_rx.push_back(7'h01);
        rx_ready   = 1'b1;
        rx_data    = 8'h01;
        move_valid = 1'b1;
        move_in    = 7'h02;
        @(negedge clk);
        rx_ready   = 1'b0;
        move_valid = 1'b0;
        wait_trig("arb_ack", 10, c);
        wait_trig("arb_move", 60, c);
        wait_fall(f);
        idle(10);
        dc = done_count;
        rx_pulse(8'hFF, rc);
        idle(3);
        check("arb_wrong_ack_done", 32'(done_count - dc), 0);
        check("arb_wrong_ack_busy", 32'(link_busy_out), 1);
        // Timer is 0 the cycle after the fall, so it reads ACK_TIMEOUT-1 at f+AckTo
        while (cyc < f + AckTo) @(negedge clk);
        rx_pulse(8'h7F, rc);
        idle(3);
        check("arb_done", 32'(done_count - dc), 1);
        check("arb_retry", 32'(retry_cnt_out), 0);
        check("arb_busy_clr", 32'(link_busy_out), 0);
        tc = trig_count;
        idle(150);
        check("arb_no_retry", 32'(trig_count - tc), 0);

        // Retry and error
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) exp_tx.push_back(8'h10);
        send_move(7'h10, vc);
        for (int k = 0; k < 4; k++) begin
            wait_trig("retry_trig", (k == 0) ? 10 : AckTo + 40, c);
            // fall -> WAIT_ACK (1) -> timer 0..AckTo-1 -> TX_START trigger (1)
            if (k == 0) check("retry_latency", 32'(c - vc), 2);
            else check("retry_spacing", 32'(c - f), 32'(AckTo + 2));
            check("retry_cnt", 32'(retry_cnt_out), 32'(k));
            wait_fall(f);
        end
        while (cyc < f + AckTo) @(negedge clk);
        check("err_not_yet", 32'(link_error_out), 0);
        @(negedge clk);
        check("err_set", 32'(link_error_out), 1);
        check("err_busy", 32'(link_busy_out), 0);
        check("err_retry", 32'(retry_cnt_out), 3);
        tc = trig_count;
        send_move(7'h12, vc);
        idle(300);
        check("err_ignore_move", 32'(trig_count - tc), 0);
        rv = rxv_count;
        exp_rx.push_back(7'h22);
        exp_tx.push_back(8'h7F);
        rx_pulse(8'h22, rc);
        wait_trig("err_rx_ack", 10, c);
        wait_fall(f);
        check("err_rx_delivered", 32'(rxv_count - rv), 1);
        check("err_sticky", 32'(link_error_out), 1);

        check("sb_tx_drained", 32'(exp_tx.size()), 0);
        check("sb_rx_drained", 32'(exp_rx.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/move_link_ctrl.md
Name: move_link_ctrl

Overview:
- Sequences the serial link between the two boards: frames local moves for the UART transmitter, waits for the peer's acknowledge, and retransmits on timeout.
- Filters received frames: delivers new moves to game_fsm and acknowledges every received move frame.
- Arbitrates the single tx channel between outgoing move frames and outgoing ACK frames.
- Sits between game_fsm/user_io and the tx/rx modules.

Parameters:
- ACK_TIMEOUT, 6_500_000, cycles to wait for an ACK after our move frame finishes (100 ms at 65 MHz).
- MAX_RETRIES, 3, retransmissions allowed after the first send before declaring link failure.
- PKT_LEN, 8, frame width; fixed at 8 for this protocol.

Ports:
- clk_in  in  1  system clock (65 MHz).
- rst_in_n  in  1  synchronous, active-low reset.
- move_valid_in  in  1  one-cycle pulse: local move ready to send.
- move_in  in  7  local move code, 7'h00-7'h7E; 7'h7F is reserved.
- rx_ready_in  in  1  one-cycle pulse from rx: frame received.
- rx_data_in  in  8  received frame.
- tx_busy_in  in  1  high while tx is shifting out a frame.
- tx_trigger_out  out  1  one-cycle pulse that starts tx.
- tx_val_out  out  8  frame presented to tx; held stable from trigger until tx_busy_in falls.
- rx_move_valid_out  out  1  one-cycle pulse: new peer move available.
- rx_move_out  out  7  peer move code; valid with the pulse and held until the next pulse.
- move_done_out  out  1  one-cycle pulse: our move was acknowledged.
- link_busy_out  out  1  high from move acceptance until ACK or error.
- link_error_out  out  1  sticky high after retries are exhausted.
- retry_cnt_out  out  2  retransmissions issued for the current move.

Behaviour:
- Frame format: move frame = {seq, move[6:0]} with move != 7'h7F; ACK frame = {seq, 7'h7F}.
- Reset (rst_in_n low at a clock edge), all outputs 0:
  - tx_seq=0, rx_exp_seq=0, ack_pending=0, timer=0.
  - State = IDLE; tx_val_out=8'h00; rx_move_out=7'h00.
  - Reset mid-frame abandons the transaction; no further trigger is issued.
- Tx side FSM: IDLE -> TX_START -> TX_WAIT -> WAIT_ACK -> IDLE or ERROR.
- IDLE:
  - On move_valid_in, latch {tx_seq, move_in}, set link_busy_out, clear retry_cnt, and go to TX_START.
  - move_valid_in in any other state is ignored.
- TX_START:
  - Wait for tx_busy_in low and a free channel; pulse tx_trigger_out for one cycle.
  - Wait for tx_busy_in high, then go to TX_WAIT.
  - If tx_busy_in does not rise within 4 cycles, proceed to TX_WAIT anyway.
- TX_WAIT: on tx_busy_in low, clear the timer and go to WAIT_ACK.
- WAIT_ACK:
  - Timer counts up each cycle.
  - ACK received with seq==tx_seq: toggle tx_seq, pulse move_done_out, clear link_busy_out, go to IDLE.
  - ACK with a mismatched seq is ignored.
  - Timer == ACK_TIMEOUT-1 with retry_cnt < MAX_RETRIES: retry_cnt++, resend the same frame via TX_START.
  - Timer == ACK_TIMEOUT-1 with retry_cnt == MAX_RETRIES: go to ERROR.
  - ACK and timeout in the same cycle: ACK wins.
- ERROR: link_error_out=1 and link_busy_out=0; move_valid_in is ignored; exit only by reset. ACK generation for received moves continues.
- Rx handling (in every state, including ERROR), on rx_ready_in:
  - rx_data_in[6:0]==7'h7F: treat as an ACK and route it to the tx FSM.
  - Otherwise it is a move frame:
    - If rx_data_in[7]==rx_exp_seq: rx_move_out<=rx_data_in[6:0], pulse rx_move_valid_out the next cycle, toggle rx_exp_seq.
    - Otherwise it is a duplicate: not delivered.
    - Either way, set ack_pending with ack_seq=rx_data_in[7].
  - A new move frame arriving while ack_pending is set overwrites ack_seq; only one ACK is outstanding.
- Tx arbitration:
  - When the channel is free, ack_pending has priority over TX_START.
  - An ACK is sent via the same trigger, busy-rise and busy-fall sequence; it does not change the tx FSM state.
  - The timer keeps counting while an ACK is being sent.
  - ack_pending clears on the ACK's trigger.
- Latency:
  - move_valid_in to tx_trigger_out is 2 cycles when tx is idle and no ACK is pending.
  - rx_ready_in to rx_move_valid_out is 1 cycle.
- Timer is 23 bits, saturating; retry_cnt never wraps.

Test Plan (ACK_TIMEOUT=100, MAX_RETRIES=3, tx model with busy=20 cycles):
- Basic send: move_in=7'h2A, pulse valid -> trigger 2 cycles later with tx_val_out=8'h2A; inject rx 8'h7F -> move_done_out pulse, tx_seq=1; next move 7'h05 -> tx_val_out=8'h85.
- Retry/error: send 7'h10 with no ACK -> 4 triggers spaced 100 cycles after each busy fall, all 8'h10, retry_cnt_out 0->3 -> link_error_out=1; a further move_valid_in produces no trigger.
- Receive: rx 8'h33 -> rx_move_valid_out pulse with rx_move_out=7'h33, then trigger with 8'h7F; repeat rx 8'h33 -> no valid pulse, ACK 8'h7F re-sent; rx 8'hB4 -> delivered as 7'h34, ACK 8'hFF.
- Arbitration: rx move 8'h01 arrives in the same cycle as move_valid_in(7'h02) -> ACK 8'h7F transmitted first, then 8'h02; wrong-seq ACK 8'hFF during WAIT_ACK is ignored; a correct ACK arriving in the timeout cycle yields move_done_out with no retry.
- Reset: drive rst_in_n low during TX_WAIT -> next cycle all outputs 0 and seqs 0; no trigger until a new move_valid_in.
